// File: rtl/aidc_lite_comp_line_buffer.sv
// aidc_lite_comp_line_buffer
// Staging buffer for compressed line fragments between the encoder and the packer.
// Byte-enable writes, a registered read port with valid/hit status,
// per-entry valid tracking, single-cycle flush and an occupancy count.
// Optional per-byte even parity: define AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN.
module aidc_lite_comp_line_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wren_i,
    input  logic [AW-1:0]           waddr_i,
    input  logic [DATA_WIDTH/8-1:0] wbe_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    rden_i,
    input  logic [AW-1:0]           raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rvalid_o,
    output logic                    rhit_o,
    input  logic                    flush_i,
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
    input  logic                    perr_inj_i,
    output logic                    perr_o,
`endif
    output logic [AW:0]             count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_merge;
    logic                  rvalid_q;
    logic                  rhit_q, rhit_d;
    logic                  rd_wr_same;

`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wr_par, rd_par, rd_calc;
    logic          perr_q, perr_d;

    // New parity for the write target; reads of the same address see it too
    always_comb begin
        wr_par = par_q[waddr_i];
        for (int unsigned k = 0; k < NB; k++) begin
            if (wbe_i[k]) wr_par[k] = ^wdata_i[8*k +: 8];
        end
        wr_par[0] = wr_par[0] ^ perr_inj_i;
        rd_par    = rd_wr_same ? wr_par : par_q[raddr_i];
        for (int unsigned k = 0; k < NB; k++) begin
            rd_calc[k] = ^rd_merge[8*k +: 8];
        end
        perr_d = rhit_d && (|(rd_calc ^ rd_par));
    end
`endif

    // Read view of the post-flush, post-write state (write-first merge)
    always_comb begin
        rd_wr_same = wren_i && (waddr_i == raddr_i);
        rhit_d     = rd_wr_same || (!flush_i && valid_q[raddr_i]);
        rd_merge   = mem_q[raddr_i];
        for (int unsigned k = 0; k < NB; k++) begin
            if (rd_wr_same && wbe_i[k]) rd_merge[8*k +: 8] = wdata_i[8*k +: 8];
        end
        rdata_d = rhit_d ? rd_merge : '0;
    end

    // Next valid map and occupancy: flush clears everything before the write lands
    always_comb begin
        valid_d = flush_i ? '0 : valid_q;
        if (wren_i) valid_d[waddr_i] = 1'b1;
        count_d = count_q;
        if (flush_i) begin
            count_d = {{AW{1'b0}}, wren_i};
        end else if (wren_i && !valid_q[waddr_i]) begin
            count_d = count_q + 1'b1;
        end
    end

    // Control state and registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rhit_q   <= 1'b0;
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            valid_q  <= valid_d;
            count_q  <= count_d;
            rvalid_q <= rden_i;
            if (rden_i) begin
                rdata_q <= rdata_d;
                rhit_q  <= rhit_d;
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
                perr_q  <= perr_d;
`endif
            end
        end
    end

    // Storage array (not reset); byte-enabled write, dropped during reset
    always_ff @(posedge clk) begin
        if (!rst && wren_i) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (wbe_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
            par_q[waddr_i] <= wr_par;
`endif
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign rhit_o   = rhit_q;
    assign count_o  = count_q;
    assign full_o   = (count_q == DEPTH_C);
    assign empty_o  = (count_q == '0);
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
    assign perr_o   = perr_q;
`endif

endmodule

// File: tb/tb_aidc_lite_comp_line_buffer.sv
// Testbench for aidc_lite_comp_line_buffer (default 64-bit x 16 configuration).
// Behavioural model: per-entry data, known-byte mask and valid flag; count is
// the population of valid entries.
module tb_aidc_lite_comp_line_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wren_i;
    logic [3:0]  waddr_i;
    logic [7:0]  wbe_i;
    logic [63:0] wdata_i;
    logic        rden_i;
    logic [3:0]  raddr_i;
    logic [63:0] rdata_o;
    logic        rvalid_o;
    logic        rhit_o;
    logic        flush_i;
    logic [4:0]  count_o;
    logic        full_o;
    logic        empty_o;
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
    logic        perr_inj_i;
    logic        perr_o;
`endif

    always #5 clk = ~clk;

    aidc_lite_comp_line_buffer #(.DATA_WIDTH(64), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .wren_i(wren_i), .waddr_i(waddr_i), .wbe_i(wbe_i), .wdata_i(wdata_i),
        .rden_i(rden_i), .raddr_i(raddr_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rhit_o(rhit_o),
        .flush_i(flush_i),
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
        .perr_inj_i(perr_inj_i), .perr_o(perr_o),
`endif
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    int checks = 0;
    int errors = 0;

    // model state
    logic [63:0] m_mem   [16];
    logic [7:0]  m_known [16];
    bit          m_valid [16];
    bit          m_bad0  [16];

    // expected outputs after the coming edge
    bit          e_rvalid, e_rhit, e_perr, e_perr_known;
    logic [63:0] e_rdata;
    logic [7:0]  e_mask;
    int          e_count;
    bit          check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] bytemask(input logic [7:0] m);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = {8{m[k]}};
        return r;
    endfunction

    task automatic step(input bit r, input bit w, input int wa, input logic [7:0] be,
                        input logic [63:0] wd, input bit rd, input int ra, input bit fl,
                        input bit inj);
        int cnt;
        @(negedge clk);
        rst = r; wren_i = w; waddr_i = 4'(wa); wbe_i = be; wdata_i = wd;
        rden_i = rd; raddr_i = 4'(ra); flush_i = fl;
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
        perr_inj_i = inj;
`endif
        if (r) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
            e_rvalid = 0; e_rhit = 0; e_rdata = '0; e_mask = 8'hFF;
            e_perr = 0; e_perr_known = 1;
        end else begin
            if (fl) for (int i = 0; i < 16; i++) m_valid[i] = 0;
            if (w) begin
                if (!m_valid[wa]) begin
                    m_known[wa] = 8'h00;
                    m_bad0[wa]  = 0;
                end
                for (int k = 0; k < 8; k++)
                    if (be[k]) m_mem[wa][8*k +: 8] = wd[8*k +: 8];
                m_known[wa] = m_known[wa] | be;
                m_bad0[wa]  = (be[0] ? 1'b0 : m_bad0[wa]) ^ inj;
                m_valid[wa] = 1;
            end
            e_rvalid = rd;
            if (rd) begin
                e_rhit       = m_valid[ra];
                e_rdata      = e_rhit ? m_mem[ra] : 64'h0;
                e_mask       = e_rhit ? m_known[ra] : 8'hFF;
                e_perr       = e_rhit && m_bad0[ra];
                e_perr_known = !e_rhit || (m_known[ra] == 8'hFF);
            end
        end
        cnt = 0;
        for (int i = 0; i < 16; i++) cnt += int'(m_valid[i]);
        e_count  = cnt;
        check_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("rvalid", rvalid_o, e_rvalid);
            chk("rhit", rhit_o, e_rhit);
            chk("rdata", rdata_o & bytemask(e_mask), e_rdata & bytemask(e_mask));
            chk("count", count_o, 64'(e_count));
            chk("full", full_o, e_count == 16);
            chk("empty", empty_o, e_count == 0);
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
            if (e_perr_known) chk("perr", perr_o, e_perr);
`endif
        end
    end

    initial begin
        rst = 1; wren_i = 0; waddr_i = 0; wbe_i = 0; wdata_i = 0;
        rden_i = 0; raddr_i = 0; flush_i = 0;
`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
        perr_inj_i = 0;
`endif
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = '0; m_known[i] = '0; m_valid[i] = 0; m_bad0[i] = 0;
        end

        step(1, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0);
        step(1, 0, 0, 8'h00, 64'h0, 0, 0, 0, 0);

        // read after reset misses
        step(0, 0, 0, 8'h00, 64'h0, 1, 3, 0, 0);
        chk("lit_rst_rvalid", rvalid_o, 1);
        chk("lit_rst_rhit", rhit_o, 0);
        chk("lit_rst_rdata", rdata_o, 64'h0);
        chk("lit_rst_count", count_o, 0);
        chk("lit_rst_empty", empty_o, 1);

        // byte-enable merge
        step(0, 1, 5, 8'hFF, 64'h1122334455667788, 0, 0, 0, 0);
        step(0, 1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0, 0);
        step(0, 0, 0, 8'h00, 64'h0, 1, 5, 0, 0);
        chk("lit_be_rdata", rdata_o, 64'h11223344AAAAAAAA);
        chk("lit_be_rhit", rhit_o, 1);
        chk("lit_be_count", count_o, 1);

        // same-cycle write and read: write-first
        step(0, 1, 2, 8'hFF, 64'hDEADBEEF, 1, 2, 0, 0);
        chk("lit_wf_rdata", rdata_o, 64'h00000000DEADBEEF);
        chk("lit_wf_rhit", rhit_o, 1);

        // fill and overwrite while full
        for (int i = 0; i < 16; i++)
            step(0, 1, i, 8'hFF, {$urandom, $urandom}, 0, 0, 0, 0);
        chk("lit_full", full_o, 1);
        chk("lit_full_count", count_o, 16);
        step(0, 1, 0, 8'hFF, 64'h0123456789ABCDEF, 0, 0, 0, 0);
        chk("lit_ovw_count", count_o, 16);

        // flush with write 7 and read 4
        step(0, 1, 7, 8'hFF, 64'h7777, 1, 4, 1, 0);
        chk("lit_fl_rhit", rhit_o, 0);
        chk("lit_fl_rdata", rdata_o, 64'h0);
        chk("lit_fl_count", count_o, 1);
        step(0, 0, 0, 8'h00, 64'h0, 1, 7, 0, 0);
        chk("lit_fl_rd7_hit", rhit_o, 1);
        chk("lit_fl_rd7_data", rdata_o, 64'h7777);

        // reset mid-stream drops the write and the read
        step(1, 1, 9, 8'hFF, 64'h9999, 1, 7, 0, 0);
        chk("lit_mrst_rvalid", rvalid_o, 0);
        chk("lit_mrst_count", count_o, 0);
        step(0, 0, 0, 8'h00, 64'h0, 1, 9, 0, 0);
        chk("lit_mrst_rhit", rhit_o, 0);

`ifdef AIDC_LITE_COMP_LINE_BUFFER_PARITY_EN
        step(0, 1, 3, 8'hFF, 64'h0F0F0F0F0F0F0F0F, 0, 0, 0, 1);
        step(0, 0, 0, 8'h00, 64'h0, 1, 3, 0, 0);
        chk("lit_par_perr", perr_o, 1);
        chk("lit_par_rhit", rhit_o, 1);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit          r, w, rd, fl;
            logic [7:0]  be;
            r  = ($urandom % 200) == 0;
            fl = ($urandom % 40) == 0;
            w  = ($urandom % 2) == 0;
            rd = ($urandom % 2) == 0;
            be = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
            step(r, w, int'($urandom % 16), be, {$urandom, $urandom}, rd,
                 int'($urandom % 16), fl, 0);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
